// File: rtl/lc3b_mem_sequencer_pkg.sv
// lc3b_types: shared LC-3b memory operation and error encodings
package lc3b_types;
    typedef enum logic {mem_op_read, mem_op_write} lc3b_mem_op;
    typedef enum logic {mem_err_none, mem_err_timeout} lc3b_mem_err;
endpackage

// File: rtl/lc3b_mem_sequencer_lane_align.sv
// lc3b_lane_align: byte-lane enables, store replication and load extraction
module lc3b_lane_align #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [$clog2(DATA_WIDTH/8)-1:0] lane,
    input  logic                            byte_sel,
    input  logic [DATA_WIDTH-1:0]           wdata,
    input  logic [DATA_WIDTH-1:0]           rdata,
    output logic [DATA_WIDTH/8-1:0]         byte_enable,
    output logic [DATA_WIDTH-1:0]           wdata_out,
    output logic [DATA_WIDTH-1:0]           rdata_out
);
    localparam int LANES = DATA_WIDTH / 8;
    logic [DATA_WIDTH-1:0] shifted;
    always_comb begin
        shifted     = rdata >> {lane, 3'b000};
        byte_enable = byte_sel ? {{(LANES-1){1'b0}}, 1'b1} << lane : '1;
        wdata_out   = byte_sel ? {LANES{wdata[7:0]}} : wdata;
        rdata_out   = byte_sel ? {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]} : rdata;
    end
endmodule

// File: rtl/lc3b_mem_sequencer.sv
// lc3b_mem_sequencer: request/response memory engine with indirection and wait-state timeout
module lc3b_mem_sequencer
    import lc3b_types::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  lc3b_mem_op              req_op,
    input  logic                    req_byte,
    input  logic                    req_indirect,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_resp
);
    localparam int LW = $clog2(DATA_WIDTH / 8);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, PTR, GAP, ACCESS, RESP} state_t;

    state_t                  state;
    lc3b_mem_op              op_q;
    lc3b_mem_err             err_q;
    logic                    byte_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [CW-1:0]           cnt_q;
    logic [DATA_WIDTH/8-1:0] lane_be;
    logic [DATA_WIDTH-1:0]   lane_wdata;
    logic [DATA_WIDTH-1:0]   lane_rdata;
    logic                    expired;

    lc3b_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .lane        (addr_q[LW-1:0]),
        .byte_sel    (byte_q),
        .wdata       (wdata_q),
        .rdata       (mem_rdata),
        .byte_enable (lane_be),
        .wdata_out   (lane_wdata),
        .rdata_out   (lane_rdata)
    );

    // the limit is hit on the cycle whose increment would reach TIMEOUT
    assign expired = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        req_ready       = (state == IDLE) && !reset;
        resp_valid      = state == RESP;
        resp_rdata      = rdata_q;
        resp_err        = err_q == mem_err_timeout;
        mem_address     = addr_q;
        mem_read        = (state == PTR) || (state == ACCESS && op_q == mem_op_read);
        mem_write       = state == ACCESS && op_q == mem_op_write;
        mem_byte_enable = state == PTR ? '1 : state == ACCESS ? lane_be : '0;
        mem_wdata       = lane_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= mem_op_read;
            err_q   <= mem_err_none;
            byte_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    op_q    <= req_op;
                    byte_q  <= req_byte;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    rdata_q <= '0;
                    err_q   <= mem_err_none;
                    cnt_q   <= '0;
                    state   <= req_indirect ? PTR : ACCESS;
                end
                PTR: if (mem_resp) begin
                    addr_q <= mem_rdata[ADDR_WIDTH-1:0];
                    state  <= GAP;
                end else if (expired) begin
                    err_q <= mem_err_timeout;
                    state <= RESP;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                GAP: begin
                    cnt_q <= '0;
                    state <= ACCESS;
                end
                ACCESS: if (mem_resp) begin
                    rdata_q <= op_q == mem_op_write ? '0 : lane_rdata;
                    state   <= RESP;
                end else if (expired) begin
                    rdata_q <= '0;
                    err_q   <= mem_err_timeout;
                    state   <= RESP;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lc3b_mem_sequencer.sv
// tb_lc3b_mem_sequencer: directed vectors for 16-bit (TIMEOUT=4) and 32-bit sequencers
module tb_lc3b_mem_sequencer;
    import lc3b_types::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    logic        a_req_valid = 0, a_req_ready, a_req_byte = 0, a_req_ind = 0;
    lc3b_mem_op  a_req_op = mem_op_read;
    logic [15:0] a_req_addr = 0, a_req_wdata = 0;
    logic        a_resp_valid, a_resp_err, a_rd, a_wr, a_mem_resp = 0;
    logic [15:0] a_resp_rdata, a_addr, a_wdata, a_rdata = 0;
    logic [1:0]  a_be;

    logic        b_req_valid = 0, b_req_ready, b_req_byte = 0;
    lc3b_mem_op  b_req_op = mem_op_read;
    logic [15:0] b_req_addr = 0, b_addr;
    logic [31:0] b_req_wdata = 0, b_resp_rdata, b_wdata, b_rdata = 0;
    logic        b_resp_valid, b_resp_err, b_rd, b_wr, b_mem_resp = 0;
    logic [3:0]  b_be;

    lc3b_mem_sequencer #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .TIMEOUT(4)) dut16 (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_op(a_req_op),
        .req_byte(a_req_byte), .req_indirect(a_req_ind), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
        .resp_err(a_resp_err), .mem_address(a_addr), .mem_read(a_rd), .mem_write(a_wr),
        .mem_byte_enable(a_be), .mem_wdata(a_wdata), .mem_rdata(a_rdata), .mem_resp(a_mem_resp)
    );

    lc3b_mem_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .TIMEOUT(255)) dut32 (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op),
        .req_byte(b_req_byte), .req_indirect(1'b0), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
        .resp_err(b_resp_err), .mem_address(b_addr), .mem_read(b_rd), .mem_write(b_wr),
        .mem_byte_enable(b_be), .mem_wdata(b_wdata), .mem_rdata(b_rdata), .mem_resp(b_mem_resp)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic req16(input lc3b_mem_op op, input logic byt, input logic ind,
                         input logic [15:0] addr, input logic [15:0] wdata);
        chk("req_ready_idle", 32'(a_req_ready), 1);
        a_req_valid = 1; a_req_op = op; a_req_byte = byt; a_req_ind = ind;
        a_req_addr = addr; a_req_wdata = wdata;
        step;
        a_req_valid = 0; a_req_ind = 0;
    endtask

    initial begin
        step;
        step;
        chk("rst_ready", 32'(a_req_ready), 0);
        chk("rst_resp_valid", 32'(a_resp_valid), 0);
        chk("rst_rdata", 32'(a_resp_rdata), 0);
        chk("rst_strobes", {30'd0, a_rd, a_wr}, 0);
        chk("rst_addr", 32'(a_addr), 0);
        chk("rst_wdata", 32'(a_wdata), 0);
        chk("rst_be", 32'(a_be), 0);
        reset = 0;
        #1;

        // word read, mem_resp on 3rd strobe cycle
        req16(mem_op_read, 0, 0, 16'h1000, 16'h0);
        chk("wr_read1", 32'(a_rd), 1);
        chk("wr_addr", 32'(a_addr), 32'h1000);
        chk("wr_be", 32'(a_be), 2'b11);
        chk("wr_nowrite", 32'(a_wr), 0);
        step;
        chk("wr_read2", 32'(a_rd), 1);
        step;
        a_mem_resp = 1; a_rdata = 16'hBEEF;
        step;
        a_mem_resp = 0;
        chk("wr_valid", 32'(a_resp_valid), 1);
        chk("wr_rdata", 32'(a_resp_rdata), 32'hBEEF);
        chk("wr_err", 32'(a_resp_err), 0);
        chk("wr_read_off", 32'(a_rd), 0);
        chk("wr_busy", 32'(a_req_ready), 0);
        step;
        chk("wr_valid_pulse", 32'(a_resp_valid), 0);

        // byte write to odd lane
        req16(mem_op_write, 1, 0, 16'h2001, 16'h12AB);
        chk("bw_write", 32'(a_wr), 1);
        chk("bw_noread", 32'(a_rd), 0);
        chk("bw_be", 32'(a_be), 2'b10);
        chk("bw_wdata", 32'(a_wdata), 32'hABAB);
        chk("bw_addr", 32'(a_addr), 32'h2001);
        step;
        chk("bw_write_hold", 32'(a_wr), 1);
        a_mem_resp = 1;
        step;
        a_mem_resp = 0;
        chk("bw_valid", 32'(a_resp_valid), 1);
        chk("bw_rdata", 32'(a_resp_rdata), 0);
        chk("bw_write_off", 32'(a_wr), 0);
        step;

        // indirect byte read
        req16(mem_op_read, 1, 1, 16'h3000, 16'h0);
        chk("ind_ptr_read", 32'(a_rd), 1);
        chk("ind_ptr_addr", 32'(a_addr), 32'h3000);
        chk("ind_ptr_be", 32'(a_be), 2'b11);
        a_mem_resp = 1; a_rdata = 16'h4000;
        step;
        a_rdata = 16'h5A7F;
        chk("ind_gap_strobes", {30'd0, a_rd, a_wr}, 0);
        chk("ind_gap_valid", 32'(a_resp_valid), 0);
        step;
        chk("ind_acc_read", 32'(a_rd), 1);
        chk("ind_acc_addr", 32'(a_addr), 32'h4000);
        step;
        a_mem_resp = 0;
        chk("ind_valid", 32'(a_resp_valid), 1);
        chk("ind_rdata", 32'(a_resp_rdata), 32'h007F);
        step;

        // timeout: four strobe cycles then error response
        req16(mem_op_read, 0, 0, 16'h0010, 16'h0);
        for (int i = 0; i < 4; i++) begin
            chk("to_strobe", 32'(a_rd), 1);
            step;
        end
        chk("to_valid", 32'(a_resp_valid), 1);
        chk("to_err", 32'(a_resp_err), 1);
        chk("to_rdata", 32'(a_resp_rdata), 0);
        chk("to_read_off", 32'(a_rd), 0);
        chk("to_busy", 32'(a_req_ready), 0);
        step;

        // mem_resp on the limit cycle is a success
        req16(mem_op_read, 0, 0, 16'h0020, 16'h0);
        step;
        step;
        step;
        chk("lim_strobe", 32'(a_rd), 1);
        a_mem_resp = 1; a_rdata = 16'h1234;
        step;
        a_mem_resp = 0;
        chk("lim_valid", 32'(a_resp_valid), 1);
        chk("lim_err", 32'(a_resp_err), 0);
        chk("lim_rdata", 32'(a_resp_rdata), 32'h1234);
        step;

        // reset during ACCESS aborts silently
        req16(mem_op_write, 0, 0, 16'h55AA, 16'h9999);
        chk("ra_write", 32'(a_wr), 1);
        reset = 1;
        #1;
        chk("ra_ready_in_reset", 32'(a_req_ready), 0);
        step;
        reset = 0;
        #1;
        chk("ra_strobes", {30'd0, a_rd, a_wr}, 0);
        chk("ra_valid", 32'(a_resp_valid), 0);
        chk("ra_be", 32'(a_be), 0);
        step;
        chk("ra_valid2", 32'(a_resp_valid), 0);
        req16(mem_op_read, 0, 0, 16'h0100, 16'h0);
        chk("ra_new_read", 32'(a_rd), 1);
        chk("ra_new_addr", 32'(a_addr), 32'h0100);
        a_mem_resp = 1; a_rdata = 16'hC0DE;
        step;
        a_mem_resp = 0;
        chk("ra_new_valid", 32'(a_resp_valid), 1);
        chk("ra_new_rdata", 32'(a_resp_rdata), 32'hC0DE);
        step;

        // 32-bit instance: byte write lane 3, word read, byte read lane 2
        chk("w32_ready", 32'(b_req_ready), 1);
        b_req_valid = 1; b_req_op = mem_op_write; b_req_byte = 1;
        b_req_addr = 16'h0003; b_req_wdata = 32'h000000CD;
        step;
        b_req_valid = 0;
        chk("w32_be", 32'(b_be), 4'b1000);
        chk("w32_wdata", b_wdata, 32'hCDCDCDCD);
        chk("w32_write", 32'(b_wr), 1);
        b_mem_resp = 1;
        step;
        b_mem_resp = 0;
        chk("w32_valid", 32'(b_resp_valid), 1);
        step;
        b_req_valid = 1; b_req_op = mem_op_read; b_req_byte = 0; b_req_addr = 16'h0004;
        step;
        b_req_valid = 0;
        chk("r32_be", 32'(b_be), 4'b1111);
        b_mem_resp = 1; b_rdata = 32'hDEADBEEF;
        step;
        b_mem_resp = 0;
        chk("r32_rdata", b_resp_rdata, 32'hDEADBEEF);
        step;
        b_req_valid = 1; b_req_byte = 1; b_req_addr = 16'h0006;
        step;
        b_req_valid = 0;
        b_mem_resp = 1; b_rdata = 32'h11223344;
        step;
        b_mem_resp = 0;
        chk("rb32_rdata", b_resp_rdata, 32'h00000022);
        step;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
